zwait_multi: RTL and testbench

- Parametrised Z80 wait generator. Replaces the two-source RS-flop version.
- Collects NUM_SRC wait requests (gluclock, comport, future SPI-serviced peripherals) into a pending vector, holds Z80 /WAIT low while any request is pending, and raises an SPI interrupt to the AVR.
- Fully synchronous to fclk. Adds per-source selective release, a lowest-index-first source indicator, and a mandatory /WAIT release gap.

---
 rtl/zwait_multi.sv | 70 +++++++
 tb/tb_zwait_multi.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/zwait_multi.sv
// zwait_multi: multi-source Z80 /WAIT generator with release gap; ZWAIT_TIMEOUT_EN adds a WAIT timeout
module zwait_multi #(
  parameter int NUM_SRC = 7,
  parameter int SRC_W   = 3,
  parameter int GAP_CYC = 2,
  parameter int TMO_W   = 16
) (
  input  logic               fclk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] wait_start,
  input  logic               wait_end,
  input  logic [NUM_SRC-1:0] wait_clr,
  output logic [NUM_SRC-1:0] waits,
  output logic [SRC_W-1:0]   cur_src,
  output logic               busy,
  output logic               wait_n,
  output logic               spiint_n,
  output logic               tmo_flag
);
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  state_t             state, nxt_state;
  logic [3:0]         gap_cnt, nxt_gap;
  logic [NUM_SRC-1:0] nxt_waits;
  logic [SRC_W-1:0]   nxt_src;
  logic               tmo_hit;
`ifdef ZWAIT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  assign tmo_hit = state == WAIT && &tmo_cnt;
  always_ff @(posedge fclk or posedge rst)
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_cnt  <= state == WAIT ? tmo_cnt + 1'b1 : '0;
      tmo_flag <= tmo_flag | tmo_hit;
    end
`else
  assign tmo_hit = 1'b0;
  // TMO_W only sizes the timeout counter; this is a constant 0
  assign tmo_flag = TMO_W < 0;
`endif
  always_comb begin
    nxt_waits = tmo_hit ? '0 : (waits & ~(wait_end ? wait_clr : '0)) | wait_start;
    nxt_src = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (nxt_waits[i]) nxt_src = SRC_W'(i);
  end
  always_comb begin
    nxt_state = state == IDLE ? (|nxt_waits ? WAIT : IDLE) :
                state == WAIT ? (|nxt_waits ? WAIT : GAP) :
                (gap_cnt == 4'd0 ? IDLE : GAP);
    nxt_gap = state == WAIT && !(|nxt_waits) ? 4'(GAP_CYC - 1) :
              state != IDLE && state != WAIT && gap_cnt != 4'd0 ? gap_cnt - 4'd1 : gap_cnt;
  end
  always_ff @(posedge fclk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      waits   <= '0;
      cur_src <= '0;
    end else begin
      state   <= nxt_state;
      gap_cnt <= nxt_gap;
      waits   <= nxt_waits;
      cur_src <= nxt_src;
    end
  assign busy     = state != IDLE;
  assign wait_n   = state == WAIT ? 1'b0 : 1'bz;
  assign spiint_n = ~|waits;
endmodule

// File: tb/tb_zwait_multi.sv
// tb_zwait_multi: directed checks of zwait_multi in its default build
module tb_zwait_multi;
  logic       fclk = 1'b0, rst = 1'b1, wait_end = 1'b0;
  logic [6:0] wait_start = '0, wait_clr = '0, waits;
  logic [2:0] cur_src;
  logic       busy, spiint_n, tmo_flag;
  wire        wait_n;
  int         n_vec = 0, n_err = 0;
  pullup (wait_n);
  zwait_multi dut (
    .fclk(fclk), .rst(rst), .wait_start(wait_start), .wait_end(wait_end),
    .wait_clr(wait_clr), .waits(waits), .cur_src(cur_src), .busy(busy),
    .wait_n(wait_n), .spiint_n(spiint_n), .tmo_flag(tmo_flag)
  );
  always #5 fclk = ~fclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge fclk);
    #1;
  endtask
  task automatic drive(input logic [6:0] s, input logic e, input logic [6:0] c);
    wait_start = s;
    wait_end   = e;
    wait_clr   = c;
  endtask
  initial begin
    #3;
    chk("rst_waits", waits, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_spiint_n", spiint_n, 1);
    chk("rst_tmo_flag", tmo_flag, 0);
    @(negedge fclk);
    rst = 1'b0;
    drive(7'b0000001, 0, 0);
    tick();
    drive(0, 0, 0);
    chk("single_waits", waits, 7'b0000001);
    chk("single_cur_src", cur_src, 0);
    chk("single_wait_n", wait_n, 0);
    chk("single_spiint_n", spiint_n, 0);
    chk("single_busy", busy, 1);
    drive(0, 1, 7'b0000001);
    tick();
    drive(0, 0, 0);
    chk("release_waits", waits, 0);
    chk("release_spiint_n", spiint_n, 1);
    chk("gap1_wait_n", wait_n, 1);
    chk("gap1_busy", busy, 1);
    tick();
    chk("gap2_wait_n", wait_n, 1);
    chk("gap2_busy", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
    drive(7'b0010010, 0, 0);
    tick();
    drive(0, 0, 0);
    chk("sel_waits", waits, 7'b0010010);
    chk("sel_cur_src", cur_src, 1);
    drive(0, 1, 7'b0000010);
    tick();
    drive(0, 0, 0);
    chk("sel_part_waits", waits, 7'b0010000);
    chk("sel_part_cur_src", cur_src, 4);
    chk("sel_part_wait_n", wait_n, 0);
    drive(0, 1, 7'b0000000);
    tick();
    drive(0, 0, 0);
    chk("noclr_waits", waits, 7'b0010000);
    chk("noclr_wait_n", wait_n, 0);
    drive(0, 1, 7'b0010000);
    tick();
    drive(0, 0, 0);
    chk("sel_last_waits", waits, 0);
    chk("sel_last_wait_n", wait_n, 1);
    chk("sel_last_busy", busy, 1);
    tick();
    tick();
    chk("sel_idle_busy", busy, 0);
    drive(7'b1000001, 0, 0);
    tick();
    drive(0, 1, 7'b0000001);
    chk("hi_cur_src", cur_src, 0);
    tick();
    drive(0, 0, 0);
    chk("hi_waits", waits, 7'b1000000);
    chk("hi_cur_src6", cur_src, 6);
    drive(0, 1, 7'b1000000);
    tick();
    drive(0, 0, 0);
    tick();
    tick();
    chk("hi_idle_busy", busy, 0);
    drive(7'b0000100, 0, 0);
    tick();
    chk("col_cur_src", cur_src, 2);
    drive(7'b0000100, 1, 7'b0000100);
    tick();
    chk("col_waits", waits, 7'b0000100);
    chk("col_wait_n", wait_n, 0);
    drive(7'b0000100, 0, 0);
    tick();
    drive(0, 0, 0);
    chk("hold_waits", waits, 7'b0000100);
    drive(0, 1, 7'b0000100);
    tick();
    drive(7'b0001000, 0, 0);
    chk("rs_gap_a_wait_n", wait_n, 1);
    chk("rs_gap_a_waits", waits, 0);
    tick();
    drive(0, 0, 0);
    chk("rs_gap_b_wait_n", wait_n, 1);
    chk("rs_gap_b_busy", busy, 1);
    chk("rs_gap_b_waits", waits, 7'b0001000);
    chk("rs_gap_b_spiint_n", spiint_n, 0);
    chk("rs_gap_b_cur_src", cur_src, 3);
    tick();
    chk("rs_idle_wait_n", wait_n, 1);
    chk("rs_idle_busy", busy, 0);
    tick();
    chk("rs_wait_wait_n", wait_n, 0);
    chk("rs_wait_cur_src", cur_src, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wait_n", wait_n, 1);
    chk("arst_waits", waits, 0);
    chk("arst_busy", busy, 0);
    chk("arst_spiint_n", spiint_n, 1);
    @(negedge fclk);
    rst = 1'b0;
    tick();
    chk("post_rst_waits", waits, 0);
    chk("post_rst_wait_n", wait_n, 1);
    chk("post_rst_tmo_flag", tmo_flag, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
